// File: rtl/fib_seq_ctrl.sv
// -----------------------------------------------------------------------------
// fib_seq_ctrl
//
// Sequencer for the BCD -> Fibonacci -> BCD display chain. A go request runs
// the chain once: bcd2bin, then fib, then bin2bcd. The controller holds the
// operands for each stage stable and range-checks each intermediate result.
// It latches the final four BCD digits for the display multiplexer. The
// 4-digit display sets the limits: n <= N_MAX and F(n) <= 9999.
//
// Optional feature: define FIB_SEQ_TIMEOUT_EN to build a per-stage watchdog.
// The watchdog aborts a stage after TO_CYC cycles with err_code 2'b11.
//
// Parameters
//   W       binary datapath width
//   N_MAX   largest accepted n
//   TO_CYC  per-stage watchdog limit in cycles (only with FIB_SEQ_TIMEOUT_EN)
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous reset, active low
//   go         run request, sampled only while idle
//   b2b_start  1-cycle start pulse to bcd2bin
//   b2b_done   bcd2bin done tick
//   b2b_bin    bcd2bin result (n)
//   fib_start  1-cycle start pulse to fib
//   fib_i      registered n to fib
//   fib_done   fib done tick
//   fib_f      fib result F(n)
//   b2d_start  1-cycle start pulse to bin2bcd
//   b2d_bin    registered F(n) to bin2bcd
//   b2d_done   bin2bcd done tick
//   b2d_bcd    {bcd3,bcd2,bcd1,bcd0} from bin2bcd
//   hex        latched digits to the display multiplexer
//   busy       high whenever a run is in progress
//   done_tick  1-cycle pulse when a run ends (success or error)
//   err        error flag of the last run, cleared by the next accepted go
//   err_code   00 none, 01 n > N_MAX, 10 F(n) > 9999, 11 watchdog timeout
// -----------------------------------------------------------------------------
module fib_seq_ctrl #(
    parameter int W      = 20,
    parameter int N_MAX  = 20,
    parameter int TO_CYC = 65535
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         go,
    output logic         b2b_start,
    input  logic         b2b_done,
    input  logic [W-1:0] b2b_bin,
    output logic         fib_start,
    output logic [W-1:0] fib_i,
    input  logic         fib_done,
    input  logic [W-1:0] fib_f,
    output logic         b2d_start,
    output logic [W-1:0] b2d_bin,
    input  logic         b2d_done,
    input  logic [15:0]  b2d_bcd,
    output logic [15:0]  hex,
    output logic         busy,
    output logic         done_tick,
    output logic         err,
    output logic [1:0]   err_code
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        B2B  = 2'd1,
        FIB  = 2'd2,
        B2D  = 2'd3
    } state_t;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_RANGE = 2'b01;
    localparam logic [1:0] ERR_OVF   = 2'b10;

    // Limits widened to the full datapath so the comparisons never truncate.
    localparam logic [W-1:0] N_MAX_W = W'(N_MAX);
    localparam logic [W-1:0] F_MAX_W = W'(9999);

    state_t        state_reg, state_next;
    logic          b2b_start_reg, b2b_start_next;
    logic          fib_start_reg, fib_start_next;
    logic          b2d_start_reg, b2d_start_next;
    logic [W-1:0]  fib_i_reg, fib_i_next;
    logic [W-1:0]  b2d_bin_reg, b2d_bin_next;
    logic [15:0]   hex_reg, hex_next;
    logic          busy_reg, busy_next;
    logic          done_tick_reg, done_tick_next;
    logic          err_reg, err_next;
    logic [1:0]    err_code_reg, err_code_next;

`ifdef FIB_SEQ_TIMEOUT_EN
    localparam int            CW          = $clog2(TO_CYC + 1);
    localparam logic [1:0]    ERR_TIMEOUT = 2'b11;
    // The counter holds the number of completed cycles in the current state.
    // It reads TO_CYC-1 while the TO_CYC-th cycle is in progress, so the
    // abort takes effect exactly TO_CYC cycles after the state was entered.
    localparam logic [CW-1:0] TO_LAST     = CW'(TO_CYC - 1);

    logic [CW-1:0] to_cnt_reg, to_cnt_next;
    logic          timeout;

    assign timeout = (state_reg != IDLE) && (to_cnt_reg == TO_LAST);

    always_comb begin
        to_cnt_next = to_cnt_reg;
        if (state_next != state_reg) begin
            to_cnt_next = '0;
        end else if (state_reg != IDLE) begin
            to_cnt_next = to_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            to_cnt_reg <= '0;
        end else begin
            to_cnt_reg <= to_cnt_next;
        end
    end
`endif

    // Next-state and next-output logic. Every output is a register, so each
    // start pulse and done_tick appears in the cycle after the deciding edge.
    always_comb begin
        state_next     = state_reg;
        b2b_start_next = 1'b0;
        fib_start_next = 1'b0;
        b2d_start_next = 1'b0;
        done_tick_next = 1'b0;
        fib_i_next     = fib_i_reg;
        b2d_bin_next   = b2d_bin_reg;
        hex_next       = hex_reg;
        err_next       = err_reg;
        err_code_next  = err_code_reg;

        case (state_reg)
            IDLE: begin
                // A done input arriving here is ignored. Only go is looked at.
                if (go) begin
                    state_next     = B2B;
                    b2b_start_next = 1'b1;
                    err_next       = 1'b0;
                    err_code_next  = ERR_NONE;
                end
            end
            B2B: begin
                if (b2b_done) begin
                    if (b2b_bin > N_MAX_W) begin
                        state_next     = IDLE;
                        err_next       = 1'b1;
                        err_code_next  = ERR_RANGE;
                        done_tick_next = 1'b1;
                    end else begin
                        state_next     = FIB;
                        fib_i_next     = b2b_bin;
                        fib_start_next = 1'b1;
                    end
                end
            end
            FIB: begin
                if (fib_done) begin
                    if (fib_f > F_MAX_W) begin
                        state_next     = IDLE;
                        err_next       = 1'b1;
                        err_code_next  = ERR_OVF;
                        done_tick_next = 1'b1;
                    end else begin
                        state_next     = B2D;
                        b2d_bin_next   = fib_f;
                        b2d_start_next = 1'b1;
                    end
                end
            end
            B2D: begin
                if (b2d_done) begin
                    state_next     = IDLE;
                    hex_next       = b2d_bcd;
                    done_tick_next = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

`ifdef FIB_SEQ_TIMEOUT_EN
        // A stage that completes on the same edge wins over the watchdog.
        // The watchdog only aborts a stage that is still waiting.
        if (timeout && (state_next == state_reg)) begin
            state_next     = IDLE;
            b2b_start_next = 1'b0;
            fib_start_next = 1'b0;
            b2d_start_next = 1'b0;
            err_next       = 1'b1;
            err_code_next  = ERR_TIMEOUT;
            done_tick_next = 1'b1;
        end
`endif

        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            b2b_start_reg <= 1'b0;
            fib_start_reg <= 1'b0;
            b2d_start_reg <= 1'b0;
            fib_i_reg     <= '0;
            b2d_bin_reg   <= '0;
            hex_reg       <= '0;
            busy_reg      <= 1'b0;
            done_tick_reg <= 1'b0;
            err_reg       <= 1'b0;
            err_code_reg  <= ERR_NONE;
        end else begin
            state_reg     <= state_next;
            b2b_start_reg <= b2b_start_next;
            fib_start_reg <= fib_start_next;
            b2d_start_reg <= b2d_start_next;
            fib_i_reg     <= fib_i_next;
            b2d_bin_reg   <= b2d_bin_next;
            hex_reg       <= hex_next;
            busy_reg      <= busy_next;
            done_tick_reg <= done_tick_next;
            err_reg       <= err_next;
            err_code_reg  <= err_code_next;
        end
    end

    assign b2b_start = b2b_start_reg;
    assign fib_start = fib_start_reg;
    assign b2d_start = b2d_start_reg;
    assign fib_i     = fib_i_reg;
    assign b2d_bin   = b2d_bin_reg;
    assign hex       = hex_reg;
    assign busy      = busy_reg;
    assign done_tick = done_tick_reg;
    assign err       = err_reg;
    assign err_code  = err_code_reg;

endmodule

// File: tb/tb_fib_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fib_seq_ctrl
//
// Bench for fib_seq_ctrl. Behavioural stage models return their results
// L cycles after the start pulse is seen. A run-level reference model predicts
// every registered output cycle by cycle from the run's n and F(n). Per-run
// literal expectations (digits, error code, latency) pin that model. Build
// with FIB_SEQ_TIMEOUT_EN to check the watchdog variant.
// -----------------------------------------------------------------------------
module tb_fib_seq_ctrl;

    localparam int W     = 20;
    localparam int N_MAX = 20;
    localparam int TO_T  = 16;
    localparam int L     = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          go = 1'b0;
    logic          b2b_start, fib_start, b2d_start;
    logic          b2b_done, fib_done, b2d_done;
    logic [W-1:0]  b2b_bin = '0;
    logic [W-1:0]  fib_i, b2d_bin;
    logic [W-1:0]  fib_f = '0;
    logic [15:0]   b2d_bcd = '0;
    logic [15:0]   hex;
    logic          busy, done_tick, err;
    logic [1:0]    err_code;

    // Stage model state and stimulus knobs
    int            c_b2b = 0, c_fib = 0, c_b2d = 0;
    logic          b2b_done_m = 1'b0, fib_done_m = 1'b0, b2d_done_m = 1'b0;
    logic          stray_b2b = 1'b0, stray_fib = 1'b0, stray_b2d = 1'b0;
    logic          fib_force_en = 1'b0, fib_hang = 1'b0;
    logic [W-1:0]  fib_force_val = '0;

    assign b2b_done = b2b_done_m | stray_b2b;
    assign fib_done = fib_done_m | stray_fib;
    assign b2d_done = b2d_done_m | stray_b2d;

    fib_seq_ctrl #(.W(W), .N_MAX(N_MAX), .TO_CYC(TO_T)) dut (
        .clk(clk), .reset(reset), .go(go),
        .b2b_start(b2b_start), .b2b_done(b2b_done), .b2b_bin(b2b_bin),
        .fib_start(fib_start), .fib_i(fib_i), .fib_done(fib_done), .fib_f(fib_f),
        .b2d_start(b2d_start), .b2d_bin(b2d_bin), .b2d_done(b2d_done), .b2d_bcd(b2d_bcd),
        .hex(hex), .busy(busy), .done_tick(done_tick), .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W-1:0] fib_ref(input logic [W-1:0] n);
        int a, b, t;
        if (n > 30) return '1;
        a = 0; b = 1;
        for (int i = 0; i < int'(n); i++) begin
            t = a + b; a = b; b = t;
        end
        return W'(a);
    endfunction

    function automatic logic [15:0] bcd_ref(input int v);
        logic [15:0] r;
        r[15:12] = 4'((v / 1000) % 10);
        r[11:8]  = 4'((v / 100) % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[3:0]   = 4'(v % 10);
        return r;
    endfunction

    // Stage models: a start seen at edge e produces done sampled at edge e+L.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            c_b2b <= 0; b2b_done_m <= 1'b0;
        end else begin
            if (b2b_start) c_b2b <= L; else if (c_b2b != 0) c_b2b <= c_b2b - 1;
            b2b_done_m <= (c_b2b == 2) && !b2b_start;
        end
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            c_fib <= 0; fib_done_m <= 1'b0;
        end else begin
            if (fib_start) c_fib <= L; else if (c_fib != 0) c_fib <= c_fib - 1;
            fib_done_m <= 1'b0;
            if ((c_fib == 2) && !fib_start && !fib_hang) begin
                fib_done_m <= 1'b1;
                fib_f      <= fib_force_en ? fib_force_val : fib_ref(fib_i);
            end
        end
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            c_b2d <= 0; b2d_done_m <= 1'b0;
        end else begin
            if (b2d_start) c_b2d <= L; else if (c_b2d != 0) c_b2d <= c_b2d - 1;
            b2d_done_m <= 1'b0;
            if ((c_b2d == 2) && !b2d_start) begin
                b2d_done_m <= 1'b1;
                b2d_bcd    <= bcd_ref(int'(b2d_bin));
            end
        end
    end

    // Run description written by the stimulus, consumed by the checker
    int           run_seq = 0, run_k = 0;
    logic [W-1:0] run_n = '0, run_fv = '0;
    logic         run_hang = 1'b0;
    logic         pin_en = 1'b0, pin_err = 1'b0;
    logic [1:0]   pin_code = '0;
    logic [15:0]  pin_hex = '0;
    logic [W-1:0] pin_fi = '0, pin_bb = '0;
    int           pin_lat = 0, pin_fs = 0;

    // Checker-owned state
    int           done_seq = 0;
    int           n_chk = 0, n_fail = 0;
    int           fs_cnt = 0, first_dt = -1;
    logic [15:0]  p_hex = '0;
    logic [W-1:0] p_fi = '0, p_bb = '0;
    logic         p_err = 1'b0;
    logic [1:0]   p_code = '0;

    task automatic chk(input string nm, input logic [31:0] act_v, input logic [31:0] exp_v);
        n_chk++;
        if (act_v !== exp_v) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act_v, exp_v);
        end
    endtask

    always @(negedge clk) begin
        logic [15:0]  e_hex;
        logic [W-1:0] e_fi, e_bb;
        logic         e_err, e_b2bs, e_fibs, e_b2ds, e_busy, e_dt, act, n_ok, f_ok;
        logic [1:0]   e_code;
        int           done_e;

        if (!reset) begin
            p_hex = '0; p_fi = '0; p_bb = '0; p_err = 1'b0; p_code = '0;
            done_seq = run_seq;
        end
        act = (run_seq != done_seq);
        e_hex = p_hex; e_fi = p_fi; e_bb = p_bb; e_err = p_err; e_code = p_code;
        e_b2bs = 1'b0; e_fibs = 1'b0; e_b2ds = 1'b0; e_busy = 1'b0; e_dt = 1'b0;
        n_ok = 1'b0; f_ok = 1'b0; done_e = 0;

        if (act) begin
            n_ok = (run_n <= N_MAX);
            f_ok = n_ok && !run_hang && (run_fv <= 9999);
            if (!n_ok)          done_e = run_k + 1 + L;
            else if (run_hang) begin
`ifdef FIB_SEQ_TIMEOUT_EN
                done_e = run_k + 1 + L + TO_T;
`else
                done_e = run_k + 1000000;
`endif
            end
            else if (!f_ok)     done_e = run_k + 2 + 2 * L;
            else                done_e = run_k + 3 + 3 * L;

            if (cyc == run_k) begin fs_cnt = 0; first_dt = -1; end
            e_b2bs = (cyc == run_k);
            e_fibs = n_ok && (cyc == run_k + 1 + L);
            if (n_ok && cyc >= run_k + 1 + L) e_fi = run_n;
            e_b2ds = f_ok && (cyc == run_k + 2 + 2 * L);
            if (f_ok && cyc >= run_k + 2 + 2 * L) e_bb = run_fv;
            if (cyc < done_e) begin
                e_busy = 1'b1; e_err = 1'b0; e_code = 2'b00;
            end else begin
                e_dt = 1'b1; e_err = 1'b1;
                if (!n_ok)         e_code = 2'b01;
                else if (run_hang) e_code = 2'b11;
                else if (!f_ok)    e_code = 2'b10;
                else begin
                    e_err = 1'b0; e_code = 2'b00; e_hex = bcd_ref(int'(run_fv));
                end
            end
        end

        chk("b2b_start", 32'(b2b_start), 32'(e_b2bs));
        chk("fib_start", 32'(fib_start), 32'(e_fibs));
        chk("b2d_start", 32'(b2d_start), 32'(e_b2ds));
        chk("fib_i",     32'(fib_i),     32'(e_fi));
        chk("b2d_bin",   32'(b2d_bin),   32'(e_bb));
        chk("hex",       32'(hex),       32'(e_hex));
        chk("busy",      32'(busy),      32'(e_busy));
        chk("done_tick", 32'(done_tick), 32'(e_dt));
        chk("err",       32'(err),       32'(e_err));
        chk("err_code",  32'(err_code),  32'(e_code));

        if (act) begin
            if (fib_start) fs_cnt++;
            if (done_tick && first_dt < 0) first_dt = cyc - run_k;
            if (cyc == done_e) begin
                p_hex = e_hex; p_fi = e_fi; p_bb = e_bb; p_err = e_err; p_code = e_code;
                if (pin_en) begin
                    chk("pin_hex",      32'(hex),      32'(pin_hex));
                    chk("pin_err",      32'(err),      32'(pin_err));
                    chk("pin_err_code", 32'(err_code), 32'(pin_code));
                    chk("pin_fib_i",    32'(fib_i),    32'(pin_fi));
                    chk("pin_b2d_bin",  32'(b2d_bin),  32'(pin_bb));
                    chk("pin_latency",  32'(first_dt), 32'(pin_lat));
                    chk("pin_fib_starts", 32'(fs_cnt), 32'(pin_fs));
                end
                done_seq = run_seq;
            end
        end
    end

    task automatic set_pin(input logic [15:0] h, input logic e, input logic [1:0] c,
                           input int lat, input logic [W-1:0] fi, input logic [W-1:0] bb,
                           input int fs);
        pin_en = 1'b1; pin_hex = h; pin_err = e; pin_code = c;
        pin_lat = lat; pin_fi = fi; pin_bb = bb; pin_fs = fs;
    endtask

    // Called just after a rising edge; go is sampled at the following edge.
    task automatic start_run(input logic [W-1:0] n, input logic fen, input logic [W-1:0] fval,
                             input logic hang, input int hold);
        b2b_bin = n; fib_force_en = fen; fib_force_val = fval; fib_hang = hang;
        go = 1'b1;
        @(posedge clk); #1;
        run_k = cyc; run_n = n; run_fv = fen ? fval : fib_ref(n); run_hang = hang;
        run_seq = run_seq + 1;
        for (int i = 1; i < hold; i++) begin @(posedge clk); #1; end
        go = 1'b0;
    endtask

    task automatic wait_done();
        while (done_seq != run_seq) begin @(posedge clk); #1; end
    endtask

    task automatic pulse_reset(input int len);
        reset = 1'b0;
        repeat (len) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;

        // Basic run, n=10
        set_pin(16'h0055, 1'b0, 2'b00, 12, 20'd10, 20'd55, 1);
        start_run(20'd10, 1'b0, '0, 1'b0, 1); wait_done();
        // Largest accepted n
        set_pin(16'h6765, 1'b0, 2'b00, 12, 20'd20, 20'd6765, 1);
        start_run(20'd20, 1'b0, '0, 1'b0, 1); wait_done();
        // n out of range: fib never started, display keeps last good value
        set_pin(16'h6765, 1'b1, 2'b01, 4, 20'd20, 20'd6765, 0);
        start_run(20'd21, 1'b0, '0, 1'b0, 1); wait_done();
        // Fib result just above and at the display limit
        set_pin(16'h6765, 1'b1, 2'b10, 8, 20'd7, 20'd6765, 1);
        start_run(20'd7, 1'b1, 20'd10000, 1'b0, 1); wait_done();
        set_pin(16'h9999, 1'b0, 2'b00, 12, 20'd3, 20'd9999, 1);
        start_run(20'd3, 1'b1, 20'd9999, 1'b0, 1); wait_done();
        // go held for 10 cycles gives one run, then a stray fib_done in IDLE
        set_pin(16'h0144, 1'b0, 2'b00, 12, 20'd12, 20'd144, 1);
        start_run(20'd12, 1'b0, '0, 1'b0, 10); wait_done();
        stray_fib = 1'b1; @(posedge clk); #1; stray_fib = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        // b2b_done together with go in IDLE is ignored
        set_pin(16'h0021, 1'b0, 2'b00, 12, 20'd8, 20'd21, 1);
        stray_b2b = 1'b1;
        start_run(20'd8, 1'b0, '0, 1'b0, 1);
        stray_b2b = 1'b0;
        wait_done();
        // b2d_done arriving during FIB is ignored
        set_pin(16'h0034, 1'b0, 2'b00, 12, 20'd9, 20'd34, 1);
        start_run(20'd9, 1'b0, '0, 1'b0, 1);
        repeat (5) begin @(posedge clk); #1; end
        stray_b2d = 1'b1; @(posedge clk); #1; stray_b2d = 1'b0;
        wait_done();
        // n=0
        set_pin(16'h0000, 1'b0, 2'b00, 12, 20'd0, 20'd0, 1);
        start_run(20'd0, 1'b0, '0, 1'b0, 1); wait_done();
        // Reset during FIB aborts the run, then a fresh run with n=5
        pin_en = 1'b0;
        start_run(20'd15, 1'b0, '0, 1'b0, 1);
        repeat (6) begin @(posedge clk); #1; end
        pulse_reset(3);
        set_pin(16'h0005, 1'b0, 2'b00, 12, 20'd5, 20'd5, 1);
        start_run(20'd5, 1'b0, '0, 1'b0, 1); wait_done();
        // fib never answers
`ifdef FIB_SEQ_TIMEOUT_EN
        set_pin(16'h0005, 1'b1, 2'b11, 4 + TO_T, 20'd6, 20'd5, 1);
        start_run(20'd6, 1'b0, '0, 1'b1, 1); wait_done();
        fib_hang = 1'b0;
`else
        pin_en = 1'b0;
        start_run(20'd6, 1'b0, '0, 1'b1, 1);
        repeat (40) begin @(posedge clk); #1; end
        pulse_reset(2);
        fib_hang = 1'b0;
`endif
        // Randomised runs
        pin_en = 1'b0;
        for (int r = 0; r < 40; r++) begin
            int kind;
            kind = $urandom_range(0, 9);
            if (kind < 2)
                start_run(W'($urandom_range(21, 20'hFFFFF)), 1'b0, '0, 1'b0, $urandom_range(1, 4));
            else if (kind < 4)
                start_run(W'($urandom_range(0, 20)), 1'b1, W'($urandom_range(0, 20000)), 1'b0,
                          $urandom_range(1, 4));
            else
                start_run(W'($urandom_range(0, 20)), 1'b0, '0, 1'b0, $urandom_range(1, 4));
            wait_done();
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        end

        repeat (2) begin @(posedge clk); #1; end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
